// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA stream receiver: timing check, lock FSM, x/y/valid and colour regeneration
module vga_sync_rx #(
    parameter int H_VISIBLE   = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_VISIBLE   = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_R,
    input  logic       in_G,
    input  logic       in_B,
    input  logic       in_hsync,
    input  logic       in_vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       valid,
    output logic       newline,
    output logic       newframe,
    output logic       out_R,
    output logic       out_G,
    output logic       out_B,
    output logic       locked,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_TO   = 10'(H_TOTAL);
    localparam logic [9:0] H_SW   = 10'(H_SYNC);
    localparam logic [9:0] H_ACT0 = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT1 = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT1 = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
    localparam int         GW     = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

    logic [4:0]    s1;          // {R, G, B, hsync, vsync}
    logic [3:0]    s2;          // {R, G, B, hsync}
    logic [9:0]    hcount, vcount, lowcnt;
    logic          seen_edge, vs_line;
    logic [GW-1:0] good, good_nxt;
    state_t        state, state_nxt;
    logic          err_inc, lock_nxt, pix_ok, nl_d, nf_d;
    logic          h_fall, v_start, line_err, frame_ok, h_act, v_act;

    // hcount/vcount describe the pixel currently held in s2
    assign h_fall   = s2[0] & ~s1[1];
    assign v_start  = h_fall & ~s1[0] & vs_line;
    assign line_err = h_fall ? (seen_edge && (hcount != H_LAST || lowcnt != H_SW))
                             : (hcount == H_TO);
    assign frame_ok = (vcount == V_LAST);
    assign h_act    = (hcount >= H_ACT0) && (hcount <= H_ACT1);
    assign v_act    = (vcount >= V_ACT0) && (vcount <= V_ACT1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1        <= '1;
            s2        <= '1;
            hcount    <= '0;
            lowcnt    <= '0;
            vcount    <= '0;
            seen_edge <= 1'b0;
            vs_line   <= 1'b1;
        end else begin
            s1 <= {in_R, in_G, in_B, in_hsync, in_vsync};
            s2 <= s1[4:1];
            if (h_fall)
                hcount <= '0;
            else if (hcount != 10'h3FF)
                hcount <= hcount + 10'd1;
            if (h_fall)
                lowcnt <= 10'd1;
            else if (!s1[1] && lowcnt != 10'h3FF)
                lowcnt <= lowcnt + 10'd1;
            if (h_fall) begin
                seen_edge <= 1'b1;
                vs_line   <= s1[0];
            end
            if (v_start)
                vcount <= '0;
            else if (h_fall && vcount != 10'h3FF)
                vcount <= vcount + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_SEARCH;
            good      <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        err_inc   = 1'b0;
        case (state)
            ST_SEARCH: begin
                good_nxt = '0;
                if (v_start)
                    state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                // a line error outranks a frame pass on the same edge
                if (line_err) begin
                    state_nxt = ST_SEARCH;
                    good_nxt  = '0;
                end else if (v_start) begin
                    if (frame_ok) begin
                        good_nxt = good + GW'(1);
                        if (good + GW'(1) == GOOD_LOCK)
                            state_nxt = ST_LOCKED;
                    end else begin
                        good_nxt = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_err || (v_start && !frame_ok)) begin
                    state_nxt = ST_SEARCH;
                    good_nxt  = '0;
                    err_inc   = 1'b1;
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    // pixels and strobes follow the state that governs them, so the
    // error pixel is already invalid and the lock edge already strobes
    always_comb begin
        locked   = (state == ST_LOCKED);
        lock_nxt = (state_nxt == ST_LOCKED);
        pix_ok   = lock_nxt & h_act & v_act;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= 1'b0;
            x        <= '0;
            y        <= '0;
            out_R    <= 1'b0;
            out_G    <= 1'b0;
            out_B    <= 1'b0;
            nl_d     <= 1'b0;
            nf_d     <= 1'b0;
            newline  <= 1'b0;
            newframe <= 1'b0;
        end else begin
            valid    <= pix_ok;
            x        <= pix_ok ? hcount - H_ACT0 : '0;
            y        <= pix_ok ? vcount - V_ACT0 : '0;
            out_R    <= pix_ok & s2[3];
            out_G    <= pix_ok & s2[2];
            out_B    <= pix_ok & s2[1];
            nl_d     <= h_fall & lock_nxt;
            nf_d     <= v_start & lock_nxt;
            newline  <= nl_d;
            newframe <= nf_d;
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - directed bench for vga_sync_rx on a scaled-down raster
module tb_vga_sync_rx;

    localparam int HV = 6, HS = 2, HB = 2, HT = 12;
    localparam int VV = 3, VS = 1, VB = 1, VT = 6;
    localparam int HA0 = HS + HB, VA0 = VS + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_R = 1'b1, in_G = 1'b1, in_B = 1'b1, in_hsync = 1'b1, in_vsync = 1'b1;
    logic [9:0] x, y;
    logic       valid, newline, newframe, out_R, out_G, out_B, locked;
    logic [7:0] err_count;

    int errors = 0, checks = 0;
    int nvalid = 0, nnl = 0, nnf = 0;
    logic [25:0] pipe [0:2];
    logic        lk_obs [0:15];
    logic [7:0]  ec_obs [0:15];

    vga_sync_rx #(
        .H_VISIBLE(HV), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_R(in_R), .in_G(in_G), .in_B(in_B), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .x(x), .y(y), .valid(valid), .newline(newline), .newframe(newframe),
        .out_R(out_R), .out_G(out_G), .out_B(out_B), .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Output word {valid, x, y, R, G, B, newline, newframe}; a pixel driven
    // after edge k is expected on the outputs after edge k+3.
    task automatic drive_pix(input int col, input logic hs, input logic vs,
                             input logic r, input logic g, input logic b, input logic [25:0] e);
        logic [25:0] obs;
        @(posedge clk);
        #1;
        obs = {valid, x, y, out_R, out_G, out_B, newline, newframe};
        checks++;
        assert (obs === pipe[2]) else begin
            errors++;
            $error("FAIL pix col=%0d obs=%h exp=%h", col, obs, pipe[2]);
        end
        lk_obs[col] = locked;
        ec_obs[col] = err_count;
        nvalid += int'(valid);
        nnl    += int'(newline);
        nnf    += int'(newframe);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
        in_hsync = hs;
        in_vsync = vs;
        in_R = r;
        in_G = g;
        in_B = b;
    endtask

    task automatic send_line(input int line, input int len, input bit hs_en, input bit exp_lk);
        logic [9:0]  xv, yv;
        logic        hs, vs, r, g, b, in_act, nl;
        logic [25:0] e;
        for (int c = 0; c < len; c++) begin
            hs = !(hs_en && c < HS);
            vs = !(line < VS);
            xv = 10'(c - HA0);
            yv = 10'(line - VA0);
            in_act = (c >= HA0) && (c < HA0 + HV) && (line >= VA0) && (line < VA0 + VV);
            if (in_act) begin
                r = xv[0]; g = yv[0]; b = xv[1];
            end else begin
                r = 1'b1; g = 1'b1; b = 1'b1;
            end
            nl = exp_lk && hs_en && (c == 0);
            e  = (exp_lk && in_act) ? {1'b1, xv, yv, r, g, b, 2'b00} : 26'd0;
            e[1] = nl;
            e[0] = nl && (line == 0);
            drive_pix(c, hs, vs, r, g, b, e);
        end
    endtask

    task automatic send_frame(input int nlines, input bit exp_lk);
        for (int l = 0; l < nlines; l++)
            send_line(l, HT, 1'b1, exp_lk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_xy", int'({x, y}), 0);
        chk("rst_flags", int'({valid, newline, newframe, out_R, out_G, out_B, locked}), 0);
        chk("rst_err", int'(err_count), 0);
        @(negedge clk);
        rst = 1'b1;

        // nominal lock: two measured frames, frame 3 regenerated with colour ramp
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b0);
        chk("lock_before_f3", int'(locked), 0);
        nvalid = 0; nnl = 0; nnf = 0;
        send_line(0, HT, 1'b1, 1'b1);
        chk("lock_rise_c1", int'(lk_obs[1]), 0);
        chk("lock_rise_c2", int'(lk_obs[2]), 1);
        for (int l = 1; l < VT; l++) send_line(l, HT, 1'b1, 1'b1);
        send_frame(VT, 1'b1);
        chk("nom_valid_cycles", nvalid, 2 * HV * VV);
        chk("nom_newlines", nnl, 2 * VT);
        chk("nom_newframes", nnf, 2);
        chk("nom_err", int'(err_count), 0);

        // one line shortened by a clock while locked
        send_line(0, HT, 1'b1, 1'b1);
        send_line(1, HT, 1'b1, 1'b1);
        send_line(2, HT - 1, 1'b1, 1'b1);
        send_line(3, HT, 1'b1, 1'b0);
        chk("short_lock_c1", int'(lk_obs[1]), 1);
        chk("short_lock_c2", int'(lk_obs[2]), 0);
        chk("short_err_c1", int'(ec_obs[1]), 0);
        chk("short_err_c2", int'(ec_obs[2]), 1);
        send_line(4, HT, 1'b1, 1'b0);
        send_line(5, HT, 1'b1, 1'b0);
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b0);
        chk("relock_pending", int'(locked), 0);

        // relocked frame, then hsync missing on line 3
        send_line(0, HT, 1'b1, 1'b1);
        chk("relock", int'(locked), 1);
        send_line(1, HT, 1'b1, 1'b1);
        send_line(2, HT, 1'b1, 1'b1);
        send_line(3, HT, 1'b0, 1'b0);
        chk("tmo_lock_c2", int'(lk_obs[2]), 1);
        chk("tmo_lock_c3", int'(lk_obs[3]), 0);
        chk("tmo_err_c2", int'(ec_obs[2]), 1);
        chk("tmo_err_c3", int'(ec_obs[3]), 2);
        send_line(4, HT, 1'b1, 1'b0);
        send_line(5, HT, 1'b1, 1'b0);

        // frame one line short while measuring restarts the good-frame count
        send_frame(VT, 1'b0);
        send_frame(VT - 1, 1'b0);
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b0);
        chk("short_frame_nolock", int'(locked), 0);
        for (int l = 0; l < 4; l++) send_line(l, HT, 1'b1, 1'b1);
        chk("short_frame_lock", int'(locked), 1);

        // asynchronous reset mid-frame
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_xy", int'({x, y}), 0);
        chk("mid_rst_flags", int'({valid, newline, newframe, out_R, out_G, out_B, locked}), 0);
        chk("mid_rst_err", int'(err_count), 0);
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        for (int i = 0; i < 4; i++) drive_pix(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 26'd0);
        rst = 1'b1;
        nnf = 0;
        send_frame(VT, 1'b0);
        send_frame(VT, 1'b0);
        chk("post_rst_nf", nnf, 0);
        chk("post_rst_nolock", int'(locked), 0);
        send_frame(VT, 1'b1);
        chk("post_rst_relock_nf", nnf, 1);

        // repeated lock losses saturate err_count
        for (int i = 0; i < 300; i++) begin
            send_line(0, HT - 1, 1'b1, 1'b1);
            for (int l = 1; l < VT; l++) send_line(l, HT, 1'b1, 1'b0);
            if (i == 0) chk("sat_first", int'(err_count), 1);
            if (i == 254) chk("sat_255", int'(err_count), 255);
            send_frame(VT, 1'b0);
            send_frame(VT, 1'b0);
        end
        chk("sat_final", int'(err_count), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receive-side counterpart of the VGA output path: samples an incoming 640x480 VGA stream (1-bit R/G/B, active-low hsync/vsync) on the pixel clock. It checks the stream against the expected timing and locks after consecutive good frames. Once locked, it regenerates x/y coordinates, a valid flag, newline/newframe strobes and registered pixel colour. It is used for loopback self-test of the video output and for capturing screens into downstream checkers.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_SYNC, 96, hsync low width in clocks
- H_BACK, 48, back porch in clocks
- H_TOTAL, 800, clocks per line
- V_VISIBLE, 480, active lines per frame
- V_SYNC, 2, vsync low width in lines
- V_BACK, 33, back porch in lines
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- clk  in  1  pixel clock (25 MHz); inputs are synchronous to it
- rst  in  1  asynchronous, active-low reset
- in_R, in_G, in_B  in  1 each  incoming colour
- in_hsync, in_vsync  in  1 each  incoming sync, active low
- x  out  10  pixel column, 0..H_VISIBLE-1 while valid
- y  out  10  pixel row, 0..V_VISIBLE-1 while valid
- valid  out  1  pixel in active area and locked
- newline  out  1  one-clock pulse per line while locked
- newframe  out  1  one-clock pulse per frame while locked
- out_R, out_G, out_B  out  1 each  pixel colour aligned with x/y/valid; 0 when not valid
- locked  out  1  timing lock status
- err_count  out  8  saturating count of lock losses

## Operation
- Input stage: all five inputs are registered into s1, then s2. A falling edge is s2=1 and s1=0.
- hcount (10 bit):
  - Loads 0 on an hsync falling edge; otherwise increments.
  - Saturates at 1023.
  - hsync low width is measured as the count of s1=0 cycles since the edge.
- vcount (10 bit):
  - Loads 0 on an hsync falling edge coinciding with vsync low when the previous line had vsync high (vsync start).
  - Increments on every other hsync falling edge.
- Line check, at each hsync falling edge after the first: previous hcount must equal H_TOTAL-1, and the low width must equal H_SYNC.
- Timeout: hcount reaching H_TOTAL with no edge is a line error.
- Frame check, at vsync start: vcount must equal V_TOTAL-1, with all lines of the frame good.
- FSM states: SEARCH, MEASURE, LOCKED.
  - SEARCH: good=0. On vsync start -> MEASURE.
  - MEASURE: a line error returns to SEARCH. A passing frame check increments good; if good reaches LOCK_FRAMES -> LOCKED, otherwise stay in MEASURE. A failing frame check -> MEASURE with good=0 (the new frame starts here).
  - LOCKED: any line or frame error -> SEARCH, with err_count incremented (saturating at 255).
- Active area:
  - h_act = hcount in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1].
  - v_act = vcount in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE-1].
  - x = hcount-(H_SYNC+H_BACK); y = vcount-(V_SYNC+V_BACK).
- valid = locked & h_act & v_act. When not valid, x/y hold 0 and out_RGB are 0.
- newline: pulse on each hsync falling edge while LOCKED.
- newframe: pulse on vsync start while LOCKED; it coincides with that line's newline.

## Timing
- Reset (rst=0) values:
  - FSM=SEARCH; all counters 0; s1/s2=1.
  - All outputs 0, including err_count.
- Latency: the pixel on the input pins at rising edge k appears on out_RGB, with its x/y/valid, after rising edge k+3 (s1, s2, output register). newline/newframe use the same latency.
- locked rises on the clock after the LOCK_FRAMES-th passing frame check. The first valid pixel comes from the frame that starts at that vsync start.
- locked and valid drop on the clock after an error is detected. The same edge increments err_count; the error pixel is not valid.
- hcount/vcount wrap is driven only by sync edges and never by internal terminal counts.
- Reset asserted mid-frame clears everything immediately. After release, lock requires a fresh vsync start plus LOCK_FRAMES good frames.
- Simultaneous line error and frame pass on the same edge: the error wins.

## Test plan
- Nominal 640x480@60 source, 4 frames -> locked=1 after end of frame 2; in frame 3, pixel (0,0) has x=0,y=0,valid=1; exactly 480 newline-with-valid lines, each with 640 valid cycles; err_count=0.
- Colour ramp (R=x[0], G=y[0], B=x[5]) -> out_RGB matches at every valid (x,y) with 3-clock latency.
- Once locked, one line shortened to 799 clocks -> locked=0 and valid=0 on the next clock; err_count=1; relock after 2 further good frames.
- Once locked, hsync removed -> at hcount=800, locked drops and err_count increments; err_count saturates at 255 after 300 injected errors.
- Frame with 524 lines during MEASURE -> good resets; locked only after 2 following good frames.
- Reset asserted at line 200 of a locked frame -> all outputs 0 within the async assert; no newframe until relocked.
